branch_predict_pipef: RTL and testbench

Fetch-stage branch predictor for the pipelined core: a direct-mapped table of 2-bit saturating counters plus a tagged branch target buffer (BTB), looked up with the fetch PC each cycle. It sits at the opposite end of branch resolution. The execute-stage branch unit reports each resolved branch (taken/not-taken, target) back here. This block trains its tables from that report and raises a registered mispredict/redirect to the PC mux and the pipeline flush logic.

---
 rtl/branch_predict_pipef_pkg.sv | 12 +
 rtl/branch_predict_pipef_sat_counter2.sv | 13 +
 rtl/branch_predict_pipef.sv | 94 +++++++++
 tb/tb_branch_predict_pipef.sv | 124 ++++++++++++
 4 files changed

// File: rtl/branch_predict_pipef_pkg.sv
// branch_predict_pipef_pkg: shared counter encodings, default sizing and PC helper
package branch_predict_pipef_pkg;
  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT = 2'b10;
  localparam logic [1:0] CNT_ST = 2'b11;
  localparam logic [1:0] CNT_RST = CNT_WNT;
  localparam int DEF_IDX_W = 6;
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/branch_predict_pipef_sat_counter2.sv
// sat_counter2: combinational 2-bit saturating counter next-state
module sat_counter2
  import branch_predict_pipef_pkg::*;
(
  input  logic [1:0] count,
  input  logic       taken,
  output logic [1:0] next
);
  // step toward taken/not-taken, clamping at the strong states
  always_comb
    next = taken ? ((count == CNT_ST) ? CNT_ST : count + 2'd1)
                 : ((count == CNT_SNT) ? CNT_SNT : count - 2'd1);
endmodule

// File: rtl/branch_predict_pipef.sv
// branch_predict_pipef: fetch-stage bimodal predictor + tagged BTB; optional stats via BPRED_STATS_EN
module branch_predict_pipef
  import branch_predict_pipef_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int TAG_W = 32 - 2 - IDX_W
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [31:0] iFetchPC,
  output logic        oPredTaken,
  output logic [31:0] oPredTarget,
  input  logic        iUpdValid,
  input  logic [31:0] iUpdPC,
  input  logic        iUpdTaken,
  input  logic [31:0] iUpdTarget,
  input  logic        iUpdPredTaken,
  input  logic [31:0] iUpdPredTarget,
  output logic        oMispredict,
  output logic [31:0] oRedirectPC,
  output logic [31:0] oStatBranches,
  output logic [31:0] oStatMispredicts
);
  localparam int DEPTH = 1 << IDX_W;
  logic [1:0]       cnt [DEPTH];
  logic             vld [DEPTH];
  logic [TAG_W-1:0] tag [DEPTH];
  logic [31:0]      tgt [DEPTH];
  logic [IDX_W-1:0] fidx, uidx;
  logic [TAG_W-1:0] ftag, utag;
  logic [1:0]       cnt_nxt;
  logic             hit, mis;
  logic [3:0]       unused_pc_lsbs;
  assign fidx = iFetchPC[IDX_W+1:2];
  assign ftag = iFetchPC[31:IDX_W+2];
  assign uidx = iUpdPC[IDX_W+1:2];
  assign utag = iUpdPC[31:IDX_W+2];
  assign unused_pc_lsbs = {iFetchPC[1:0], iUpdPC[1:0]};
  // combinational lookup from current table contents (no update bypass)
  always_comb begin
    hit = vld[fidx] && (tag[fidx] == ftag);
    oPredTaken = hit && cnt[fidx][1];
    oPredTarget = oPredTaken ? tgt[fidx] : pc_next(iFetchPC);
    mis = iUpdValid && ((iUpdTaken != iUpdPredTaken) || (iUpdTaken && (iUpdTarget != iUpdPredTarget)));
  end
  sat_counter2 u_sat (
    .count(cnt[uidx]),
    .taken(iUpdTaken),
    .next (cnt_nxt)
  );
  // counters and valid bits need async clear, so they live in flops
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt[i] <= CNT_RST;
        vld[i] <= 1'b0;
      end
    end else if (iUpdValid) begin
      cnt[uidx] <= cnt_nxt;
      if (iUpdTaken) vld[uidx] <= 1'b1;
    end
  // tags and targets are only meaningful behind a valid bit, so no reset
  always_ff @(posedge iCLK)
    if (iRST_N && iUpdValid && iUpdTaken) begin
      tag[uidx] <= utag;
      tgt[uidx] <= iUpdTarget;
    end
  // one-cycle registered redirect pulse toward PC mux and flush logic
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      oMispredict <= 1'b0;
      oRedirectPC <= '0;
    end else begin
      oMispredict <= mis;
      oRedirectPC <= mis ? (iUpdTaken ? iUpdTarget : pc_next(iUpdPC)) : '0;
    end
`ifdef BPRED_STATS_EN
  logic [31:0] n_br, n_mis;
  // saturating resolved-branch and mispredict counters
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      n_br <= '0;
      n_mis <= '0;
    end else begin
      if (iUpdValid && ~&n_br) n_br <= n_br + 32'd1;
      if (mis && ~&n_mis) n_mis <= n_mis + 32'd1;
    end
  assign oStatBranches = n_br;
  assign oStatMispredicts = n_mis;
`else
  assign oStatBranches = '0;
  assign oStatMispredicts = '0;
`endif
endmodule

// File: tb/tb_branch_predict_pipef.sv
// tb_branch_predict_pipef: directed scoreboard bench for branch_predict_pipef
module tb_branch_predict_pipef;
  logic iCLK = 1'b0, iRST_N;
  logic [31:0] iFetchPC, iUpdPC, iUpdTarget, iUpdPredTarget;
  logic iUpdValid, iUpdTaken, iUpdPredTaken;
  logic oPredTaken, oMispredict;
  logic [31:0] oPredTarget, oRedirectPC, oStatBranches, oStatMispredicts;
  typedef struct packed {logic mis; logic [31:0] rd;} exp_t;
  exp_t q[$];
  int tests = 0, failed = 0, n_br = 0, n_mis = 0;
  always #5 iCLK = ~iCLK;
  branch_predict_pipef dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iFetchPC(iFetchPC), .oPredTaken(oPredTaken),
    .oPredTarget(oPredTarget), .iUpdValid(iUpdValid), .iUpdPC(iUpdPC),
    .iUpdTaken(iUpdTaken), .iUpdTarget(iUpdTarget), .iUpdPredTaken(iUpdPredTaken),
    .iUpdPredTarget(iUpdPredTarget), .oMispredict(oMispredict), .oRedirectPC(oRedirectPC),
    .oStatBranches(oStatBranches), .oStatMispredicts(oStatMispredicts)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_out();
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("mispredict", {31'd0, oMispredict}, {31'd0, e.mis});
      if (e.mis) chk("redirect", oRedirectPC, e.rd);
    end else chk("mispredict_idle", {31'd0, oMispredict}, 32'd0);
  endtask
  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tg,
                     input logic pt, input logic [31:0] ptg);
    exp_t e;
    @(negedge iCLK);
    check_out();
    iUpdValid = 1'b1; iUpdPC = pc; iUpdTaken = t; iUpdTarget = tg;
    iUpdPredTaken = pt; iUpdPredTarget = ptg;
    e.mis = (t != pt) || (t && (tg != ptg));
    e.rd = t ? tg : pc + 32'd4;
    q.push_back(e);
    n_br++;
    if (e.mis) n_mis++;
  endtask
  task automatic idle();
    @(negedge iCLK);
    check_out();
    iUpdValid = 1'b0;
  endtask
  task automatic look(input string tag, input logic [31:0] pc, input logic et, input logic [31:0] etg);
    iFetchPC = pc;
    #1;
    chk({tag, "_taken"}, {31'd0, oPredTaken}, {31'd0, et});
    chk({tag, "_target"}, oPredTarget, etg);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    iRST_N = 1'b0; iFetchPC = '0; iUpdValid = 1'b0; iUpdPC = '0; iUpdTaken = 1'b0;
    iUpdTarget = '0; iUpdPredTaken = 1'b0; iUpdPredTarget = '0;
    #12;
    chk("rst_mispredict", {31'd0, oMispredict}, 32'd0);
    chk("rst_redirect", oRedirectPC, 32'd0);
    chk("rst_stat_br", oStatBranches, 32'd0);
    chk("rst_stat_mis", oStatMispredicts, 32'd0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    look("reset_lookup", 32'h0040_0000, 1'b0, 32'h0040_0004);
    upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
    look("no_bypass", 32'h0040_0010, 1'b0, 32'h0040_0014);
    upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
    look("after_t1", 32'h0040_0010, 1'b1, 32'h0040_0100);
    idle();
    look("after_t2", 32'h0040_0010, 1'b1, 32'h0040_0100);
    upd(32'h0040_0010, 1'b0, 32'h0, 1'b1, 32'h0040_0100);
    idle();
    look("nt1", 32'h0040_0010, 1'b1, 32'h0040_0100);
    upd(32'h0040_0010, 1'b0, 32'h0, 1'b1, 32'h0040_0100);
    idle();
    look("nt2", 32'h0040_0010, 1'b0, 32'h0040_0014);
    upd(32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0040_0014);
    upd(32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0040_0014);
    upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
    idle();
    look("hold00", 32'h0040_0010, 1'b0, 32'h0040_0014);
    upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
    idle();
    look("retrain", 32'h0040_0010, 1'b1, 32'h0040_0100);
    look("alias", 32'h0040_0110, 1'b0, 32'h0040_0114);
    upd(32'h0050_0000, 1'b1, 32'h0000_2000, 1'b1, 32'h0000_1000);
    upd(32'h0050_0000, 1'b1, 32'h0000_2000, 1'b1, 32'h0000_2000);
    upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0000_3000);
    idle();
    idle();
`ifdef BPRED_STATS_EN
    chk("stat_br", oStatBranches, n_br);
    chk("stat_mis", oStatMispredicts, n_mis);
`else
    chk("stat_br_tied", oStatBranches, 32'd0);
    chk("stat_mis_tied", oStatMispredicts, 32'd0);
`endif
    @(negedge iCLK);
    check_out();
    iUpdValid = 1'b1; iUpdPC = 32'h0040_0010; iUpdTaken = 1'b1; iUpdTarget = 32'h0040_0200;
    iUpdPredTaken = 1'b0; iUpdPredTarget = 32'h0040_0014;
    iRST_N = 1'b0;
    @(negedge iCLK);
    chk("rstupd_mispredict", {31'd0, oMispredict}, 32'd0);
    chk("rstupd_stat_br", oStatBranches, 32'd0);
    chk("rstupd_stat_mis", oStatMispredicts, 32'd0);
    iUpdValid = 1'b0;
    iRST_N = 1'b1;
    look("post_rst", 32'h0040_0010, 1'b0, 32'h0040_0014);
    idle();
    idle();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
